// File: rtl/trng_postproc.sv
// trng_postproc: von Neumann debiaser + LSB-first word packer with valid/ready output
// and a sticky repetition-count health test on the raw stream.
module trng_postproc #(
  parameter int WORD_WIDTH = 8,
  parameter int REP_LIMIT  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  raw_bit,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  health_fail
);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORD_WIDTH);

  typedef enum logic {EMPTY, HAVE_FIRST} pair_t;

  pair_t                 pair_q, pair_d;
  logic                  a_q, a_d, prev_q, prev_d;
  logic [RW-1:0]         rep_q, rep_d;
  logic [WORD_WIDTH-1:0] sr_q, sr_d, nsr, dout_q, dout_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  full_q, full_d, valid_q, valid_d, fail_q, fail_d;
  logic                  emit, slot_free;

  always_comb begin
    pair_d = pair_q;
    a_d = a_q;
    prev_d = prev_q;
    rep_d = rep_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    full_d = full_q;
    dout_d = dout_q;
    valid_d = valid_q & ~data_ready;
    fail_d = fail_q;
    nsr = {a_q, sr_q[WORD_WIDTH-1:1]};
    emit = enable && pair_q == HAVE_FIRST && a_q != raw_bit;
    slot_free = ~valid_q | data_ready;
    if (!enable) begin
      pair_d = EMPTY;
      rep_d = '0;
    end else begin
      pair_d = pair_q == EMPTY ? HAVE_FIRST : EMPTY;
      a_d = raw_bit;
      prev_d = raw_bit;
      rep_d = (rep_q != '0 && raw_bit == prev_q) ? (rep_q == REP_MAX ? rep_q : rep_q + RW'(1)) : RW'(1);
      fail_d = fail_q | (rep_d == REP_MAX);
    end
    // A failed source freezes the packer; a word already presented can still drain.
    if (!fail_q) begin
      if (full_q) begin
        if (slot_free) begin
          dout_d = sr_q;
          valid_d = 1'b1;
          full_d = 1'b0;
          cnt_d = '0;
        end
      end else if (emit) begin
        sr_d = nsr;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = slot_free ? '0 : CNT_FULL;
          full_d = ~slot_free;
          dout_d = slot_free ? nsr : dout_q;
          valid_d = slot_free | valid_d;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_q <= EMPTY;
      a_q <= 1'b0;
      prev_q <= 1'b0;
      rep_q <= '0;
      sr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      dout_q <= '0;
      valid_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pair_q <= pair_d;
      a_q <= a_d;
      prev_q <= prev_d;
      rep_q <= rep_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      fail_q <= fail_d;
    end
  end

  assign data_out = dout_q;
  assign data_valid = valid_q;
  assign health_fail = fail_q;
endmodule

// File: tb/tb_trng_postproc.sv
// tb_trng_postproc: scoreboard bench for trng_postproc (WORD_WIDTH=8, REP_LIMIT=32).
module tb_trng_postproc;
  logic clock = 0, reset = 1, enable = 0, raw_bit = 0, data_ready = 0;
  logic [7:0] data_out;
  logic data_valid, health_fail;
  int checks = 0, errors = 0, vcount = 0, v0;
  logic [7:0] exp_q[$];

  trng_postproc #(.WORD_WIDTH(8), .REP_LIMIT(32)) dut (
    .clock(clock), .reset(reset), .enable(enable), .raw_bit(raw_bit),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .health_fail(health_fail)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (data_valid) vcount++;
    if (data_valid && data_ready && !reset) begin
      if (exp_q.size() == 0) check("spurious_word", data_valid, 0);
      else check("word", data_out, exp_q.pop_front());
    end
  end

  task automatic sample(input logic b);
    enable = 1;
    raw_bit = b;
    @(posedge clock);
    #1;
  endtask

  task automatic pair(input logic a, input logic b);
    sample(a);
    sample(b);
  endtask

  task automatic idle(input int n);
    enable = 0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1;
    enable = 0;
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clock);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_health", health_fail, 0);
    reset = 0;
    // 1: alternating 01/10 pairs -> AA, one cycle after the 16th sample
    data_ready = 1;
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 4; i++) begin pair(0, 1); pair(1, 0); end
    check("t1_valid", data_valid, 1);
    check("t1_data", data_out, 8'hAA);
    idle(1);
    check("t1_valid_one_cycle", data_valid, 0);
    // 2: all-ones and all-zeros words, then equal pairs only
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) pair(1, 0);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) pair(0, 1);
    idle(2);
    v0 = vcount;
    for (int i = 0; i < 250; i++) begin pair(0, 0); pair(1, 1); end
    idle(2);
    check("t2_no_valid", vcount - v0, 0);
    check("t2_drained", exp_q.size(), 0);
    // 3: backpressure: A in output, B held, C dropped
    data_ready = 0;
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 4; i++) begin pair(0, 1); pair(1, 0); end
    check("t3_a_valid", data_valid, 1);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) pair(1, 0);
    for (int i = 0; i < 8; i++) pair(0, 1);
    check("t3_hold", data_out, 8'hAA);
    enable = 0;
    data_ready = 1;
    @(posedge clock);
    #1;
    check("t3_b_valid", data_valid, 1);
    check("t3_b_data", data_out, 8'hFF);
    @(posedge clock);
    #1;
    check("t3_no_c", data_valid, 0);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 4; i++) begin pair(1, 0); pair(0, 1); end
    idle(2);
    check("t3_drained", exp_q.size(), 0);
    // 5: async reset after 5 debiased bits with a word pending
    data_ready = 0;
    for (int i = 0; i < 8; i++) pair(1, 0);
    for (int i = 0; i < 5; i++) pair(1, 0);
    check("t5_pre_valid", data_valid, 1);
    #2 reset = 1;
    #1;
    check("t5_rst_valid", data_valid, 0);
    check("t5_rst_data", data_out, 0);
    check("t5_rst_health", health_fail, 0);
    @(posedge clock);
    #1;
    reset = 0;
    data_ready = 1;
    exp_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) pair(0, 1);
    idle(2);
    check("t5_drained", exp_q.size(), 0);
    // 6: disable between two samples breaks the pair
    do_reset;
    sample(1);
    idle(1);
    sample(0);
    sample(1);
    exp_q.push_back(8'hFE);
    for (int i = 0; i < 7; i++) pair(1, 0);
    idle(2);
    check("t6_drained", exp_q.size(), 0);
    // 4: repetition counter, restart on disable, sticky failure
    do_reset;
    for (int i = 0; i < 31; i++) sample(1);
    idle(1);
    for (int i = 0; i < 31; i++) sample(1);
    check("t4_31_no_fail", health_fail, 0);
    sample(1);
    check("t4_fail", health_fail, 1);
    v0 = vcount;
    for (int i = 0; i < 60; i++) pair(i[0], ~i[0]);
    for (int i = 0; i < 40; i++) pair(1'($urandom_range(1)), 1'($urandom_range(1)));
    idle(3);
    check("t4_no_valid", vcount - v0, 0);
    check("t4_sticky", health_fail, 1);
    check("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
